// File: rtl/axi_read_burst_fifo.sv
// AXI4 read slave draining an AXI-Stream-filled FIFO. Addresses are ignored;
// each read burst pops the FIFO in order. Malformed requests (WRAP-reserved
// burst type or a beat size other than the bus width) are answered with
// SLVERR beats that leave the FIFO untouched.
module axi_read_burst_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [ADDR_WIDTH-1:0]         araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [1:0]                    rresp,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [2:0] SIZE_OK = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BURST, ERR} state_t;

  // R channel payload held as one register so it moves as a unit
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } rbeat_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic [7:0]            len_q, len_d;
  logic [8:0]            beat_q, beat_d;   // beats issued so far, can reach len+1
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  rbeat_t                r_q, r_d;

  logic fifo_empty, push, pop, ar_hs, r_hs, last_hs, in_burst, load, bad_req;
  logic unused_addr;

  assign unused_addr   = ^araddr;
  assign fifo_empty    = (count_q == '0);
  assign s_axis_tready = (count_q != FULL_LVL);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign ar_hs         = arvalid && arready_q;
  assign r_hs          = rvalid_q && rready;
  assign last_hs       = r_hs && r_q.last;
  assign in_burst      = (state_q == BURST) || (state_q == ERR);
  assign bad_req       = (arburst == 2'b11) || (arsize != SIZE_OK);
  // A new beat goes out when the output slot is free, data exists (error
  // bursts need none) and the burst still has beats left to issue.
  assign load = in_burst && (!rvalid_q || rready) &&
                ((state_q == ERR) || !fifo_empty) &&
                (beat_q <= {1'b0, len_q});
  assign pop  = load && (state_q == BURST);

  // FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: request decode in IDLE, last handshake ends a burst
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (ar_hs)   state_d = bad_req ? ERR : BURST;
      BURST, ERR: if (last_hs) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values: AR acceptance, beat issue, FIFO pointers
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    r_d       = r_q;
    len_d     = len_q;
    beat_d    = beat_q;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + LW'(push) - LW'(pop);
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          len_d     = arlen;
          beat_d    = '0;
        end
      end
      BURST, ERR: begin
        if (load) begin
          r_d.data = (state_q == BURST) ? mem_q[rd_ptr_q] : '0;
          r_d.resp = (state_q == BURST) ? 2'b00 : 2'b10;
          r_d.last = (beat_q[7:0] == len_q);
          rvalid_d = 1'b1;
          beat_d   = beat_q + 9'd1;
        end else if (r_hs) begin
          rvalid_d = 1'b0;
          r_d.last = 1'b0;
        end
        if (last_hs) arready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Control and R channel registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      r_q       <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      r_q       <= r_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; a full FIFO refuses pushes, so a write never hits the head slot being read
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  assign arready    = arready_q;
  assign rvalid     = rvalid_q;
  assign rdata      = r_q.data;
  assign rresp      = r_q.resp;
  assign rlast      = r_q.last;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_axi_read_burst_fifo.sv
// Bench for axi_read_burst_fifo: directed scenarios plus randomized bursts,
// checked against a transaction-level model (data queue + burst bookkeeping).
module tb_axi_read_burst_fifo;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 16;

  logic          aclk, areset;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [$clog2(DEPTH):0] fifo_level;

  axi_read_burst_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .fifo_level(fifo_level)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model
  logic [DW-1:0] q[$];        // words pushed and not yet delivered
  bit            busy, berr;
  int            blen, bidx;
  int            ar_cyc, first_cyc, last_cyc;
  logic [DW-1:0] data_seq;
  bit            prev_stall;
  logic [DW+2:0] prev_r;
  logic [6:0]    bp_pat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // a normal-burst beat sitting on R has already left the FIFO
  function automatic int exp_level();
    return q.size() - ((rvalid === 1'b1 && busy && !berr) ? 1 : 0);
  endfunction

  task automatic check_outputs();
    int lvl;
    lvl = exp_level();
    chk("fifo_level", 64'(fifo_level), 64'(lvl));
    chk("tready", 64'(s_axis_tready), 64'(lvl != DEPTH));
    chk("arready", 64'(arready), 64'(!busy));
    if (!busy) chk("rvalid_idle", 64'(rvalid), 64'd0);
    if (prev_stall) chk("stall_hold", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, prev_r}));
  endtask

  // one clock: evaluate handshakes on current inputs, update model, advance, check
  task automatic step();
    bit push_hs, ar_hs, r_hs;
    s_axis_tdata = data_seq;
    push_hs = s_axis_tvalid && s_axis_tready;
    ar_hs   = arvalid && arready;
    r_hs    = rvalid && rready;
    if (r_hs) begin
      if (!busy) chk("beat_when_idle", 64'd1, 64'd0);
      else begin
        if (berr) begin
          chk("err_data", 64'(rdata), 64'd0);
          chk("err_resp", 64'(rresp), 64'd2);
        end else begin
          if (q.size() == 0) chk("beat_no_data", 64'd1, 64'd0);
          else begin
            chk("beat_data", 64'(rdata), 64'(q[0]));
            q.delete(0);
          end
          chk("beat_resp", 64'(rresp), 64'd0);
        end
        chk("beat_last", 64'(rlast), 64'(bidx == blen));
        if (bidx == 0) first_cyc = cyc + 1;
        if (bidx == blen) begin busy = 0; last_cyc = cyc + 1; end
        bidx++;
      end
    end
    if (push_hs) begin q.push_back(s_axis_tdata); data_seq++; end
    if (ar_hs) begin
      busy = 1; berr = (arburst == 2'b11) || (arsize != 3'd2);
      blen = int'(arlen); bidx = 0; ar_cyc = cyc + 1;
    end
    prev_stall = rvalid && !rready;
    prev_r = {rdata, rresp, rlast};
    @(posedge aclk); #1; cyc++;
    if (ar_hs) arvalid = 1'b0;
    check_outputs();
  endtask

  task automatic drive_rand(input int push_pct, input int rdy_pct);
    s_axis_tvalid = ($urandom_range(99) < push_pct);
    rready        = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic send_ar(input int len, input int burst, input int size);
    arvalid = 1'b1; arlen = 8'(len); arburst = 2'(burst); arsize = 3'(size);
    araddr = $urandom;
  endtask

  task automatic wait_idle(input int budget, input int push_pct, input int rdy_pct);
    int n = 0;
    while ((busy || arvalid) && n < budget) begin
      drive_rand(push_pct, rdy_pct);
      step();
      n++;
    end
    chk("burst_done_in_budget", 64'(busy || arvalid), 64'd0);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] start;
    int k = 0;
    start = data_seq;
    s_axis_tvalid = 1'b1;
    while (int'(data_seq - start) < n && k < 100) begin step(); k++; end
    s_axis_tvalid = 1'b0;
    chk("push_done", 64'(data_seq - start), 64'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    areset = 1'b1; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    data_seq = '0; busy = 0; berr = 0; blen = 0; bidx = 0; prev_stall = 0;
    bp_pat = 7'b1001011;

    // reset state
    repeat (2) @(posedge aclk); #1;
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    #1 areset = 1'b0;
    step();
    chk("arready_after_reset", 64'(arready), 64'd1);

    // INCR burst with data ready: 2-cycle address-to-data, 1 beat per cycle
    data_seq = 32'hA0;
    push_words(4);
    send_ar(3, 1, 2);
    wait_idle(20, 0, 100);
    chk("incr_first_lat", 64'(first_cyc - ar_cyc), 64'd2);
    chk("incr_last_lat", 64'(last_cyc - ar_cyc), 64'd5);
    chk("incr_level", 64'(fifo_level), 64'd0);

    // starvation: burst before data, words trickle in one per 3 cycles
    data_seq = 32'h100;
    send_ar(7, 1, 2);
    rready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s_axis_tvalid = (i % 3 == 2);
      step();
    end
    wait_idle(50, 0, 100);
    chk("starve_beats", 64'(bidx), 64'd8);

    // backpressure with rready 1,0,0,1,0,1,1
    data_seq = 32'h200;
    push_words(4);
    send_ar(3, 1, 2);
    rready = 1'b0;
    step();
    step();
    for (int i = 0; i < 7; i++) begin
      rready = bp_pat[6-i];
      step();
    end
    wait_idle(20, 0, 100);
    chk("bp_beats", 64'(bidx), 64'd4);

    // fill to full, then drain 16 while pushing 8 more across the wrap
    data_seq = 32'h1000;
    rready = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (18) step();
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    send_ar(15, 1, 2);
    begin
      int k = 0;
      while (data_seq < 32'h1018 && k < 100) begin s_axis_tvalid = 1'b1; step(); k++; end
    end
    s_axis_tvalid = 1'b0;
    wait_idle(100, 0, 100);
    chk("wrap_level", 64'(fifo_level), 64'd8);
    send_ar(7, 1, 2);
    wait_idle(50, 0, 100);
    chk("wrap_drained", 64'(fifo_level), 64'd0);

    // error bursts: reserved burst type, then wrong beat size
    data_seq = 32'h2000;
    push_words(2);
    send_ar(1, 3, 2);
    wait_idle(20, 0, 100);
    chk("err_burst_level", 64'(fifo_level), 64'd2);
    chk("err_burst_beats", 64'(bidx), 64'd2);
    send_ar(1, 1, 3);
    wait_idle(20, 0, 100);
    chk("err_size_level", 64'(fifo_level), 64'd2);
    chk("err_size_beats", 64'(bidx), 64'd2);
    send_ar(1, 1, 2);
    wait_idle(20, 0, 100);

    // reset with a burst in flight and 3 beats outstanding
    data_seq = 32'h3000;
    push_words(4);
    send_ar(3, 1, 2);
    rready = 1'b1;
    step();
    step();
    step();
    rready = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_level", 64'(fifo_level), 64'd0);
    chk("midrst_arready", 64'(arready), 64'd0);
    q.delete(); busy = 0; prev_stall = 0;
    @(posedge aclk); #1; cyc++;
    areset = 1'b0;
    @(posedge aclk); #1; cyc++;
    chk("midrst_arready_rel", 64'(arready), 64'd1);
    rready = 1'b1;
    repeat (10) step();

    // randomized bursts with concurrent stream traffic
    data_seq = 32'h10000;
    for (int b = 0; b < 40; b++) begin
      int len, kind, bt, sz, pp, rp;
      len = $urandom_range(0, 31);
      kind = $urandom_range(0, 9);
      bt = $urandom_range(0, 2); sz = 2;
      if (kind == 0) bt = 3;
      else if (kind == 1) sz = ($urandom_range(0, 1) == 0) ? 1 : 3;
      pp = $urandom_range(20, 90);
      rp = $urandom_range(30, 100);
      repeat ($urandom_range(0, 5)) begin drive_rand(pp, rp); step(); end
      send_ar(len, bt, sz);
      wait_idle(2000, pp, rp);
      chk("rand_beats", 64'(bidx), 64'(len + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
